// File: rtl/uart_pkg.sv
// Shared definitions for the command-driven UART transmitter: command codes,
// framing state encoding and CONFIG argument bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        CMD_DATA   = 2'd0,
        CMD_CONFIG = 2'd1,
        CMD_PREDIV = 2'd2,
        CMD_SPARE  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int CFG_STOP2      = 0;
    localparam int CFG_PAR_EN     = 1;
    localparam int CFG_PAR_ODD    = 2;
    localparam int CFG_SOFT_RESET = 4;

    typedef struct packed {
        logic par_odd;
        logic par_en;
        logic stop2;
    } cfg_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with flush and occupancy count; pushes are ignored
// when full and pops are ignored when empty.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_W-1:0]             din,
    input  logic                          pop,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; only pointers and count need a known value.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// UART transmitter driven by a 2-bit command bus (data, config, prescaler).
// Build option UART_TX_GATED_STOP_EN lets stop_gate extend the stop state.
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int PREDIV_RESET = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd,
    input  logic [DATA_W-1:0]             arg,
    output logic                          cmd_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          reset_cmd_strobe,
    input  logic                          stop_gate,
    output logic                          gated_stop_support
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e            state;
    cfg_t              cfg;
    logic [DATA_W-1:0] prediv;
    logic [DATA_W-1:0] timer;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] f_prediv;
    logic [BIT_W-1:0]  bit_idx;
    logic              f_stop2;
    logic              f_par_en;
    logic              parity_bit;
    logic              stop_left;
    logic              soft_reset;
    logic              push;
    logic              pop;
    logic              bit_done;
    logic              hold_stop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

`ifdef UART_TX_GATED_STOP_EN
    assign gated_stop_support = 1'b1;
    assign hold_stop          = stop_gate;
`else
    logic unused_stop_gate;
    assign unused_stop_gate   = stop_gate;
    assign gated_stop_support = 1'b0;
    assign hold_stop          = 1'b0;
`endif

    assign soft_reset = cmd_valid && (cmd == CMD_CONFIG) && arg[CFG_SOFT_RESET];
    assign push       = cmd_valid && (cmd == CMD_DATA);
    assign pop        = (state == IDLE) && !fifo_empty && !soft_reset;
    assign bit_done   = (timer == '0);
    assign cmd_ready  = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (soft_reset),
        .push  (push),
        .din   (arg),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Live configuration; the framer copies it at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg              <= '0;
            prediv           <= DATA_W'(PREDIV_RESET);
            reset_cmd_strobe <= 1'b0;
        end else begin
            reset_cmd_strobe <= soft_reset;
            if (cmd_valid && cmd == CMD_CONFIG && !arg[CFG_SOFT_RESET]) begin
                cfg.stop2   <= arg[CFG_STOP2];
                cfg.par_en  <= arg[CFG_PAR_EN];
                cfg.par_odd <= arg[CFG_PAR_ODD];
            end
            if (cmd_valid && cmd == CMD_PREDIV) prediv <= arg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            txd        <= 1'b1;
            timer      <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            stop_left  <= 1'b0;
            f_stop2    <= 1'b0;
            f_par_en   <= 1'b0;
            f_prediv   <= '0;
        end else if (soft_reset) begin
            state <= IDLE;
            txd   <= 1'b1;
        end else begin
            if (state != IDLE && !bit_done) timer <= timer - 1'b1;
            case (state)
                IDLE: if (!fifo_empty) begin
                    state      <= START;
                    txd        <= 1'b0;
                    timer      <= prediv;
                    f_prediv   <= prediv;
                    f_stop2    <= cfg.stop2;
                    f_par_en   <= cfg.par_en;
                    shreg      <= fifo_dout;
                    parity_bit <= (^fifo_dout) ^ cfg.par_odd;
                end
                START: if (bit_done) begin
                    state   <= DATA;
                    txd     <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                    timer   <= f_prediv;
                end
                DATA: if (bit_done) begin
                    timer <= f_prediv;
                    if (bit_idx == LAST_BIT) begin
                        if (f_par_en) begin
                            state <= PARITY;
                            txd   <= parity_bit;
                        end else begin
                            state     <= STOP;
                            txd       <= 1'b1;
                            stop_left <= f_stop2;
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                PARITY: if (bit_done) begin
                    state     <= STOP;
                    txd       <= 1'b1;
                    stop_left <= f_stop2;
                    timer     <= f_prediv;
                end
                STOP: if (bit_done) begin
                    // A held stop keeps timer at zero so release is seen on the next edge.
                    if (stop_left) begin
                        stop_left <= 1'b0;
                        timer     <= f_prediv;
                    end else if (!hold_stop) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Self-checking bench for uart_cmd_tx: a waveform-list model checked every cycle,
// plus directed frames with hand-computed bit patterns and lengths.
module tb_uart_cmd_tx;
    import uart_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int PRE_RST = 3;
`ifdef UART_TX_GATED_STOP_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] arg;
    logic              cmd_ready;
    logic              txd;
    logic              busy;
    logic [2:0]        fifo_level;
    logic              reset_cmd_strobe;
    logic              stop_gate;
    logic              gated_stop_support;

    uart_cmd_tx #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (DEPTH),
        .PREDIV_RESET (PRE_RST)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd                (cmd),
        .arg                (arg),
        .cmd_ready          (cmd_ready),
        .txd                (txd),
        .busy               (busy),
        .fifo_level         (fifo_level),
        .reset_cmd_strobe   (reset_cmd_strobe),
        .stop_gate          (stop_gate),
        .gated_stop_support (gated_stop_support)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, current frame as a list of per-clock txd levels.
    logic [DATA_W-1:0] mq[$];
    bit  wave[$];
    bit  in_frame = 1'b0;
    bit  m_txd = 1'b1;
    bit  m_strobe = 1'b0;
    bit  m_stop2, m_par_en, m_par_odd;
    int  m_prediv = PRE_RST;
    int  m_frames = 0;

    function automatic void build_frame(input logic [DATA_W-1:0] d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (m_par_en) bits.push_back((^d) ^ m_par_odd);
        bits.push_back(1'b1);
        if (m_stop2) bits.push_back(1'b1);
        foreach (bits[k]) repeat (m_prediv + 1) wave.push_back(bits[k]);
    endfunction

    always @(posedge clk) begin
        int n0;
        if (reset) begin
            mq.delete();
            wave.delete();
            in_frame = 1'b0;
            m_txd    = 1'b1;
            m_strobe = 1'b0;
            m_stop2  = 1'b0;
            m_par_en = 1'b0;
            m_par_odd = 1'b0;
            m_prediv = PRE_RST;
        end else begin
            n0 = mq.size();
            if (wave.size() > 0) begin
                m_txd = wave.pop_front();
            end else if (in_frame) begin
                m_txd = 1'b1;
                if (!(GATED && stop_gate)) in_frame = 1'b0;
            end else if (n0 > 0) begin
                build_frame(mq.pop_front());
                in_frame = 1'b1;
                m_frames++;
                m_txd = wave.pop_front();
            end
            m_strobe = 1'b0;
            if (cmd_valid) begin
                case (cmd)
                    2'd0: if (n0 < DEPTH) mq.push_back(arg);
                    2'd1: if (arg[4]) begin
                        mq.delete();
                        wave.delete();
                        in_frame = 1'b0;
                        m_txd    = 1'b1;
                        m_strobe = 1'b1;
                    end else begin
                        m_stop2   = arg[0];
                        m_par_en  = arg[1];
                        m_par_odd = arg[2];
                    end
                    2'd2: m_prediv = int'(arg);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle {txd,busy,ready,strobe,level}",
                  {25'd0, txd, busy, cmd_ready, reset_cmd_strobe, fifo_level},
                  {25'd0, m_txd, (in_frame || mq.size() != 0), (mq.size() < DEPTH), m_strobe,
                   3'(mq.size())});
    end

    // History of txd/busy sampled just after each rising edge.
    logic hist  [4096];
    logic busyh [4096];
    int   cyc = 0;
    always @(posedge clk) begin
        #2;
        if (cyc < 4096) begin
            hist[cyc]  = txd;
            busyh[cyc] = busy;
        end
        cyc++;
    end

    function automatic logic [31:0] pack(input int from, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            if (from + i >= 0 && from + i < 4096) v[i] = hist[from + i];
        return v;
    endfunction

    task automatic send(input logic [1:0] c, input logic [DATA_W-1:0] a);
        cmd_valid = 1'b1;
        cmd       = c;
        arg       = a;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string name, output int t0);
        int n = 0;
        while (txd !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: no start bit within 3000 cycles", name);
        end
        t0 = cyc - 1;
    endtask

    task automatic measure(output int len);
        len = 0;
        while (busy === 1'b1 && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        int t0, len, bc, fr0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd = 2'd0;
        arg = '0;
        stop_gate = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset txd", txd, 1);
        check("reset busy", busy, 0);
        check("reset cmd_ready", cmd_ready, 1);
        check("reset fifo_level", fifo_level, 0);
        check("reset strobe", reset_cmd_strobe, 0);
        check("gated_stop_support", gated_stop_support, GATED);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame: prediv 0, 0x55.
        send(CMD_PREDIV, 8'd0);
        send(CMD_DATA, 8'h55);
        wait_start("basic", t0);
        measure(len);
        check("basic frame length", len, 10);
        check("basic bit pattern", pack(t0, 10), 32'h2AA);
        check("basic idle after stop", hist[t0 + 10], 1);

        // Parity + two stop bits at prediv 3.
        send(CMD_PREDIV, 8'd3);
        send(CMD_CONFIG, 8'h07);
        send(CMD_DATA, 8'h01);
        wait_start("parity", t0);
        measure(len);
        check("parity frame length", len, 48);
        check("parity start+bit0+bit1", pack(t0, 12), 32'h0F0);
        check("parity bit value", pack(t0 + 36, 4), 0);
        check("parity two stop bits", pack(t0 + 40, 8), 32'hFF);

        // FIFO full: six back-to-back DATA commands, prediv 3, plain framing.
        send(CMD_CONFIG, 8'h00);
        send(CMD_SPARE, 8'hFF);
        check("spare ignored busy", busy, 0);
        fr0 = m_frames;
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            send(CMD_DATA, 8'h10 + 8'(i));
            bc += int'(busy);
            if (i == 4) begin
                check("fifo cmd_ready after 5th", cmd_ready, 0);
                check("fifo level after 5th", fifo_level, 4);
            end
        end
        check("fifo level after dropped 6th", fifo_level, 4);
        @(negedge clk);
        while (busy === 1'b1 && bc < 5000) begin
            bc++;
            @(negedge clk);
        end
        check("fifo busy span (5 frames)", bc, 205);
        check("fifo model frame count", m_frames - fr0, 5);

        // Soft reset during data bit 3; config and prediv retained.
        send(CMD_CONFIG, 8'h01);
        send(CMD_DATA, 8'h00);
        send(CMD_DATA, 8'h33);
        wait_start("softrst", t0);
        repeat (16) @(negedge clk);
        send(CMD_CONFIG, 8'h10);
        check("softrst txd", txd, 1);
        check("softrst level", fifo_level, 0);
        check("softrst busy", busy, 0);
        check("softrst strobe high", reset_cmd_strobe, 1);
        @(negedge clk);
        check("softrst strobe low", reset_cmd_strobe, 0);
        send(CMD_DATA, 8'h01);
        wait_start("softrst retained", t0);
        measure(len);
        check("softrst retained cfg/prediv length", len, 44);

        // Prediv change mid-frame affects only the next frame.
        send(CMD_PREDIV, 8'd0);
        send(CMD_CONFIG, 8'h00);
        send(CMD_DATA, 8'h0F);
        send(CMD_DATA, 8'h0F);
        wait_start("midcfg", t0);
        send(CMD_PREDIV, 8'd7);
        measure(len);
        check("midcfg frame1 pattern", pack(t0, 11), 32'h61E);
        check("midcfg frame2 start", pack(t0 + 11, 8), 0);
        check("midcfg frame2 bit0", pack(t0 + 19, 8), 32'hFF);
        check("midcfg frame2 bit4", pack(t0 + 51, 8), 0);
        check("midcfg frame2 stop", pack(t0 + 83, 8), 32'hFF);
        check("midcfg busy last", busyh[t0 + 90], 1);
        check("midcfg busy end", busyh[t0 + 91], 0);

        send(CMD_PREDIV, 8'd0);
`ifdef UART_TX_GATED_STOP_EN
        stop_gate = 1'b1;
        send(CMD_DATA, 8'h00);
        wait_start("gated", t0);
        repeat (5) @(negedge clk);
        send(CMD_DATA, 8'h5A);
        repeat (23) @(negedge clk);
        check("gated stop held high", pack(t0 + 9, 21), 32'h1FFFFF);
        check("gated busy held", busy, 1);
        stop_gate = 1'b0;
        @(negedge clk);
        check("gated release idle cycle", txd, 1);
        @(negedge clk);
        check("gated next start", txd, 0);
        measure(len);
`else
        stop_gate = 1'b1;
        send(CMD_DATA, 8'h80);
        wait_start("gate ignored", t0);
        measure(len);
        check("gate ignored frame length", len, 10);
        stop_gate = 1'b0;
`endif

        // Hardware reset mid-frame, then prediv back to its reset value.
        send(CMD_PREDIV, 8'd1);
        send(CMD_DATA, 8'h00);
        wait_start("hwrst", t0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("hwrst txd", txd, 1);
        check("hwrst busy", busy, 0);
        check("hwrst level", fifo_level, 0);
        reset = 1'b0;
        send(CMD_DATA, 8'h01);
        wait_start("hwrst prediv", t0);
        measure(len);
        check("hwrst prediv restored length", len, 40);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
